scs8hd_conb_bank: RTL and testbench

Parametrised multi-channel tie-off generator, the programmable successor to the fixed HI/LO constant cell. It provides WIDTH strap outputs that sit at a safe pattern through reset and a power-up hold window, then drive a software-loaded pattern. The pattern is shifted in serially and applied atomically on a commit handshake; it can then be sticky-locked. Fixed HI/LO constants are kept for drop-in use.

---
 rtl/scs8hd_conb_bank.sv | 122 ++++++++++++
 tb/tb_scs8hd_conb_bank.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scs8hd_conb_bank.sv
// Programmable strap/tie-off bank: safe pattern through reset and a hold window,
// then a serially loaded pattern applied atomically on commit, optionally locked.
module scs8hd_conb_bank #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter logic [WIDTH-1:0] SAFE_VAL = '0,
    parameter int unsigned      HOLD_CYC = 4,
    parameter bit               LOCK_EN  = 1'b1
) (
    input  logic             CLK,
    input  logic             RESETB,
    input  logic             SIN,
    input  logic             SEN,
    input  logic             COMMIT,
    input  logic             LOCK,
    output logic [WIDTH-1:0] TIE,
    output logic             HI,
    output logic             LO,
    output logic             READY,
    output logic             ACK,
    output logic             LOCKED,
    output logic             SOUT
);

    localparam int unsigned   CW       = $clog2(HOLD_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shr_q, shr_d;
    logic [WIDTH-1:0] act_q, act_d;
    logic [WIDTH-1:0] tie_q, tie_d;
    logic             ready_q, ready_d;
    logic             ack_q, ack_d;
    logic             locked_q, locked_d;
    logic             commit_q, commit_d;
    logic             commit_ok;

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q  <= ST_HOLD;
            cnt_q    <= '0;
            shr_q    <= RST_VAL;
            act_q    <= RST_VAL;
            tie_q    <= SAFE_VAL;
            ready_q  <= 1'b0;
            ack_q    <= 1'b0;
            locked_q <= 1'b0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shr_q    <= shr_d;
            act_q    <= act_d;
            tie_q    <= tie_d;
            ready_q  <= ready_d;
            ack_q    <= ack_d;
            locked_q <= locked_d;
            commit_q <= commit_d;
        end
    end

    // The edge register tracks COMMIT in every state, so a level raised during
    // HOLD never looks like a fresh edge once RUN is reached.
    assign commit_ok = COMMIT & ~commit_q & (state_q == ST_RUN) & ~locked_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shr_d    = shr_q;
        act_d    = act_q;
        tie_d    = tie_q;
        ready_d  = ready_q;
        ack_d    = 1'b0;
        locked_d = locked_q;
        commit_d = COMMIT;

        if (SEN && !locked_q) begin
            shr_d = {shr_q[WIDTH-2:0], SIN};
        end

        case (state_q)
            ST_HOLD: begin
                cnt_d = cnt_q + CNT_ONE;
                tie_d = SAFE_VAL;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                    tie_d   = act_q;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (commit_ok) begin
                    act_d = shr_q;
                    ack_d = 1'b1;
                end
                if (LOCK_EN && LOCK) begin
                    locked_d = 1'b1;
                end
                tie_d = act_d;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    assign TIE    = tie_q;
    assign HI     = 1'b1;
    assign LO     = 1'b0;
    assign READY  = ready_q;
    assign ACK    = ack_q;
    assign LOCKED = locked_q;
    assign SOUT   = shr_q[WIDTH-1];

endmodule

// File: tb/tb_scs8hd_conb_bank.sv
// Bench for scs8hd_conb_bank: directed plan scenarios plus randomized traffic
// against a cycle-count based reference model, on LOCK_EN=1 and LOCK_EN=0 copies.
module tb_scs8hd_conb_bank;

    localparam int         HOLD = 4;
    localparam logic [7:0] RV   = 8'hA5;
    localparam logic [7:0] SV   = 8'h00;

    logic       CLK = 1'b0;
    logic       RESETB, SIN, SEN, COMMIT, LOCK;
    logic [7:0] tie0, tie1;
    logic       hi0, lo0, ready0, ack0, locked0, sout0;
    logic       hi1, lo1, ready1, ack1, locked1, sout1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_shr [2];
    logic [7:0] m_act [2];
    bit         m_locked [2];
    bit         m_ack [2];
    int         m_edges;
    bit         m_prev;

    always #5 CLK = ~CLK;

    scs8hd_conb_bank #(.WIDTH(8), .RST_VAL(RV), .SAFE_VAL(SV), .HOLD_CYC(HOLD), .LOCK_EN(1'b1)) u_dut0 (
        .CLK(CLK), .RESETB(RESETB), .SIN(SIN), .SEN(SEN), .COMMIT(COMMIT), .LOCK(LOCK),
        .TIE(tie0), .HI(hi0), .LO(lo0), .READY(ready0), .ACK(ack0), .LOCKED(locked0), .SOUT(sout0)
    );

    scs8hd_conb_bank #(.WIDTH(8), .RST_VAL(RV), .SAFE_VAL(SV), .HOLD_CYC(HOLD), .LOCK_EN(1'b0)) u_dut1 (
        .CLK(CLK), .RESETB(RESETB), .SIN(SIN), .SEN(SEN), .COMMIT(COMMIT), .LOCK(LOCK),
        .TIE(tie1), .HI(hi1), .LO(lo1), .READY(ready1), .ACK(ack1), .LOCKED(locked1), .SOUT(sout1)
    );

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_shr[i]    = RV;
            m_act[i]    = RV;
            m_locked[i] = 1'b0;
            m_ack[i]    = 1'b0;
        end
        m_edges = 0;
        m_prev  = 1'b0;
    endtask

    // Behaviour on one rising edge, using the inputs applied before it.
    task automatic model_edge();
        bit run;
        bit acc;
        run = (m_edges >= HOLD);
        for (int i = 0; i < 2; i++) begin
            acc = run && COMMIT && !m_prev && !m_locked[i];
            m_ack[i] = acc;
            if (acc) m_act[i] = m_shr[i];
            if (SEN && !m_locked[i]) m_shr[i] = {m_shr[i][6:0], SIN};
            if (run && LOCK && (i == 0)) m_locked[i] = 1'b1;
        end
        m_prev = COMMIT;
        if (m_edges < 1000000) m_edges++;
    endtask

    function automatic logic [13:0] exp_vec(input int i);
        logic rdy;
        rdy = (m_edges >= HOLD);
        return {rdy ? m_act[i] : SV, rdy, m_ack[i], m_locked[i], m_shr[i][7], 1'b1, 1'b0};
    endfunction

    function automatic logic [13:0] obs_vec(input int i);
        return (i == 0) ? {tie0, ready0, ack0, locked0, sout0, hi0, lo0}
                        : {tie1, ready1, ack1, locked1, sout1, hi1, lo1};
    endfunction

    task automatic step(input logic sin, input logic sen, input logic commit, input logic lock);
        SIN = sin; SEN = sen; COMMIT = commit; LOCK = lock;
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        RESETB = 1'b0; SIN = 0; SEN = 0; COMMIT = 0; LOCK = 0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        n_tests++;
        if (obs_vec(0) !== 14'b00000000_0_0_0_1_1_0) begin
            n_fail++; $display("FAIL reset_state: got %b expected %b", obs_vec(0), 14'b00000000_0_0_0_1_1_0);
        end
        RESETB = 1'b1;
        for (int e = 1; e <= HOLD; e++) begin
            step(0, 0, 0, 0);
            n_tests++;
            if (tie0 !== ((e < HOLD) ? 8'h00 : 8'hA5) || ready0 !== (e == HOLD) || hi0 !== 1'b1 || lo0 !== 1'b0) begin
                n_fail++; $display("FAIL hold_window edge %0d: tie=%h ready=%b hi=%b lo=%b", e, tie0, ready0, hi0, lo0);
            end
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    n_fail++; $display("FAIL hold_model dut%0d: got %b expected %b", i, obs_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_shift_commit();
        logic [7:0] pat = 8'h3C;
        logic [7:0] old = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (sout0 !== old[7-k] || tie0 !== 8'hA5 || ack0 !== 1'b0) begin
                n_fail++; $display("FAIL shift bit %0d: sout=%b tie=%h ack=%b expected sout=%b tie=a5", k, sout0, tie0, ack0, old[7-k]);
            end
            step(pat[7-k], 1, 0, 0);
        end
        step(0, 0, 1, 0);
        n_tests++;
        if (tie0 !== 8'h3C || ack0 !== 1'b1) begin
            n_fail++; $display("FAIL commit_edge: tie=%h ack=%b expected 3c 1", tie0, ack0);
        end
        step(0, 0, 0, 0);
        n_tests++;
        if (tie0 !== 8'h3C || ack0 !== 1'b0) begin
            n_fail++; $display("FAIL ack_one_cycle: tie=%h ack=%b expected 3c 0", tie0, ack0);
        end
    endtask

    task automatic test_commit_held();
        int acks = 0;
        for (int c = 0; c < 5; c++) begin
            step(0, 0, 1, 0);
            acks += int'(ack0);
        end
        step(0, 0, 0, 0);
        acks += int'(ack0);
        n_tests++;
        if (acks != 1 || tie0 !== 8'h3C) begin
            n_fail++; $display("FAIL commit_held: acks=%0d tie=%h expected 1 3c", acks, tie0);
        end
    endtask

    task automatic test_async_reset();
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        n_tests++;
        if (tie0 !== 8'h3C) begin
            n_fail++; $display("FAIL pre_async_reset: tie=%h expected 3c", tie0);
        end
        #3 RESETB = 1'b0;
        #1;
        n_tests++;
        if (tie0 !== 8'h00 || ready0 !== 1'b0 || locked0 !== 1'b0 || ack0 !== 1'b0 || sout0 !== 1'b1) begin
            n_fail++; $display("FAIL async_reset: tie=%h ready=%b locked=%b ack=%b sout=%b", tie0, ready0, locked0, ack0, sout0);
        end
        model_reset();
        #2 RESETB = 1'b1;
        for (int e = 1; e <= HOLD; e++) begin
            step(1, 1, 0, 0);
            n_tests++;
            if (obs_vec(0) !== exp_vec(0) || tie0 !== ((e < HOLD) ? 8'h00 : 8'hA5)) begin
                n_fail++; $display("FAIL restart_hold edge %0d: got %b expected %b", e, obs_vec(0), exp_vec(0));
            end
        end
    endtask

    task automatic test_hold_commit_dropped();
        int acks = 0;
        RESETB = 1'b0;
        model_reset();
        #4 RESETB = 1'b1;
        step(1, 1, 0, 0);
        step(0, 1, 1, 0);
        step(1, 1, 1, 0);
        step(1, 1, 1, 0);
        acks += int'(ack0);
        n_tests++;
        if (tie0 !== 8'hA5 || ready0 !== 1'b1) begin
            n_fail++; $display("FAIL hold_commit_tie: tie=%h ready=%b expected a5 1", tie0, ready0);
        end
        for (int c = 0; c < 3; c++) begin
            step(0, 0, 1, 0);
            acks += int'(ack0);
        end
        step(0, 0, 0, 0);
        acks += int'(ack0);
        n_tests++;
        if (acks != 0 || tie0 !== 8'hA5) begin
            n_fail++; $display("FAIL hold_commit_dropped: acks=%0d tie=%h expected 0 a5", acks, tie0);
        end
    endtask

    task automatic test_lock_commit();
        logic [7:0] p1 = 8'hF0;
        logic [7:0] p2 = 8'h0F;
        for (int k = 0; k < 8; k++) step(p1[7-k], 1, 0, 0);
        step(0, 0, 1, 1);
        n_tests++;
        if (tie0 !== 8'hF0 || ack0 !== 1'b1 || locked0 !== 1'b1) begin
            n_fail++; $display("FAIL lock_with_commit: tie=%h ack=%b locked=%b expected f0 1 1", tie0, ack0, locked0);
        end
        n_tests++;
        if (tie1 !== 8'hF0 || ack1 !== 1'b1 || locked1 !== 1'b0) begin
            n_fail++; $display("FAIL nolock_with_commit: tie=%h ack=%b locked=%b expected f0 1 0", tie1, ack1, locked1);
        end
        step(0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            step(p2[7-k], 1, 0, 0);
            n_tests++;
            if (sout0 !== 1'b1) begin
                n_fail++; $display("FAIL locked_sout bit %0d: sout=%b expected 1", k, sout0);
            end
        end
        step(0, 0, 1, 0);
        n_tests++;
        if (tie0 !== 8'hF0 || ack0 !== 1'b0 || sout0 !== 1'b1 || locked0 !== 1'b1) begin
            n_fail++; $display("FAIL locked_frozen: tie=%h ack=%b sout=%b locked=%b expected f0 0 1 1", tie0, ack0, sout0, locked0);
        end
        n_tests++;
        if (tie1 !== 8'h0F || ack1 !== 1'b1) begin
            n_fail++; $display("FAIL nolock_second_commit: tie=%h ack=%b expected 0f 1", tie1, ack1);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_lock_disabled();
        logic [7:0] p = 8'h11;
        for (int k = 0; k < 8; k++) step(p[7-k], 1, 0, 1);
        step(0, 0, 1, 1);
        n_tests++;
        if (tie1 !== 8'h11 || ack1 !== 1'b1 || locked1 !== 1'b0) begin
            n_fail++; $display("FAIL lock_disabled: tie=%h ack=%b locked=%b expected 11 1 0", tie1, ack1, locked1);
        end
        n_tests++;
        if (tie0 !== 8'hF0 || locked0 !== 1'b1) begin
            n_fail++; $display("FAIL lock_disabled_peer: tie=%h locked=%b expected f0 1", tie0, locked0);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 2; r++) begin
            RESETB = 1'b0;
            model_reset();
            #4 RESETB = 1'b1;
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 149) == 0) begin
                    #3 RESETB = 1'b0;
                    #1;
                    model_reset();
                    for (int i = 0; i < 2; i++) begin
                        n_tests++;
                        if (obs_vec(i) !== exp_vec(i)) begin
                            n_fail++; $display("FAIL rand_async_reset dut%0d: got %b expected %b", i, obs_vec(i), exp_vec(i));
                        end
                    end
                    #2 RESETB = 1'b1;
                end
                step(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 63) == 0));
                for (int i = 0; i < 2; i++) begin
                    n_tests++;
                    if (obs_vec(i) !== exp_vec(i)) begin
                        n_fail++; $display("FAIL rand cycle %0d dut%0d: got %b expected %b", c, i, obs_vec(i), exp_vec(i));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_shift_commit();
        test_commit_held();
        test_async_reset();
        test_hold_commit_dropped();
        test_lock_commit();
        test_lock_disabled();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
